// File: rtl/controle_multiciclo.sv
// Multicycle control unit: FSM that sequences fetch, decode and per-class
// execution steps and decodes the current state into datapath control lines.
module controle_multiciclo #(
  parameter int OPCODE_W    = 4,
  parameter int ULA_OP_W    = 4,
  parameter int NUM_ALU_OPS = 11,
  parameter logic [2**OPCODE_W-1:0] IMM_MASK = (2**OPCODE_W)'(16'h07C4),
  parameter int OP_JUMP     = 11,
  parameter int OP_BEQ      = 12,
  parameter int OP_LW       = 13,
  parameter int OP_SW       = 14,
  parameter int OP_HALT     = 15,
  parameter int ULA_ADD     = 0,
  parameter int ULA_SUB     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                EscCondCP,
  output logic                EscCP,
  output logic                EscIR,
  output logic                EscReg,
  output logic                LerMem,
  output logic                EscMem,
  output logic                IouD,
  output logic                RegDst,
  output logic                MemParaReg,
  output logic                ULA_A,
  output logic [1:0]          ULA_B,
  output logic [ULA_OP_W-1:0] ULA_OP,
  output logic [1:0]          FonteCP,
  output logic [3:0]          estado,
  output logic                instr_fim,
  output logic                erro_op,
  output logic                parado
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_EXEC_I    = 4'd3;
  localparam logic [3:0] S_WB_ALU    = 4'd4;
  localparam logic [3:0] S_BRANCH    = 4'd5;
  localparam logic [3:0] S_JUMP      = 4'd6;
  localparam logic [3:0] S_MEM_ADDR  = 4'd7;
  localparam logic [3:0] S_MEM_READ  = 4'd8;
  localparam logic [3:0] S_MEM_WB    = 4'd9;
  localparam logic [3:0] S_MEM_WRITE = 4'd10;
  localparam logic [3:0] S_HALT      = 4'd11;

  localparam logic [OPCODE_W-1:0] OPC_JUMP = OPCODE_W'(OP_JUMP);
  localparam logic [OPCODE_W-1:0] OPC_BEQ  = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_LW   = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW   = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_HALT = OPCODE_W'(OP_HALT);
  localparam logic [ULA_OP_W-1:0] UOP_ADD  = ULA_OP_W'(ULA_ADD);
  localparam logic [ULA_OP_W-1:0] UOP_SUB  = ULA_OP_W'(ULA_SUB);

  logic [3:0]          state_q, state_d;
  // Cleared by reset so every output reads 0 until the first edge after release.
  logic                active_q, active_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                rdst_q, rdst_d;

  logic is_alu, is_imm;

  assign is_alu = (int'(opcode) < NUM_ALU_OPS);
  assign is_imm = IMM_MASK[opcode];

  // Next-state logic; instruction class and opcode are captured in DECODE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rdst_d   = rdst_q;
    active_d = 1'b1;
    if (active_q) begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          op_d   = opcode;
          rdst_d = ~is_imm;
          if (is_alu)                  state_d = is_imm ? S_EXEC_I : S_EXEC_R;
          else if (opcode == OPC_JUMP) state_d = S_JUMP;
          else if (opcode == OPC_BEQ)  state_d = S_BRANCH;
          else if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEM_ADDR;
          else if (opcode == OPC_HALT) state_d = S_HALT;
          else                         state_d = S_FETCH;
        end
        S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
        S_MEM_ADDR:  state_d = (op_q == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
        S_HALT:      state_d = S_HALT;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      op_q     <= '0;
      rdst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      op_q     <= op_d;
      rdst_q   <= rdst_d;
    end
  end

  // Decode current state (plus mem_ready in memory waits) into control lines.
  always_comb begin
    EscCondCP  = 1'b0;
    EscCP      = 1'b0;
    EscIR      = 1'b0;
    EscReg     = 1'b0;
    LerMem     = 1'b0;
    EscMem     = 1'b0;
    IouD       = 1'b0;
    RegDst     = 1'b0;
    MemParaReg = 1'b0;
    ULA_A      = 1'b0;
    ULA_B      = 2'b00;
    ULA_OP     = '0;
    FonteCP    = 2'b00;
    estado     = '0;
    instr_fim  = 1'b0;
    erro_op    = 1'b0;
    parado     = 1'b0;
    if (active_q) begin
      estado = state_q;
      case (state_q)
        S_FETCH: begin
          LerMem = 1'b1;
          ULA_B  = 2'b01;
          ULA_OP = UOP_ADD;
          EscIR  = mem_ready;
          EscCP  = mem_ready;
        end
        S_DECODE: begin
          ULA_B  = 2'b10;
          ULA_OP = UOP_ADD;
          if (!is_alu && opcode != OPC_JUMP && opcode != OPC_BEQ &&
              opcode != OPC_LW && opcode != OPC_SW && opcode != OPC_HALT) begin
            erro_op   = 1'b1;
            instr_fim = 1'b1;
          end
        end
        S_EXEC_R: begin
          ULA_A  = 1'b1;
          ULA_OP = ULA_OP_W'(op_q);
        end
        S_EXEC_I: begin
          ULA_A  = 1'b1;
          ULA_B  = 2'b10;
          ULA_OP = ULA_OP_W'(op_q);
        end
        S_WB_ALU: begin
          EscReg    = 1'b1;
          RegDst    = rdst_q;
          instr_fim = 1'b1;
        end
        S_JUMP: begin
          EscCP     = 1'b1;
          FonteCP   = 2'b10;
          instr_fim = 1'b1;
        end
        S_BRANCH: begin
          ULA_A     = 1'b1;
          ULA_OP    = UOP_SUB;
          EscCondCP = 1'b1;
          FonteCP   = 2'b01;
          instr_fim = 1'b1;
        end
        S_MEM_ADDR: begin
          ULA_A  = 1'b1;
          ULA_B  = 2'b10;
          ULA_OP = UOP_ADD;
        end
        S_MEM_READ: begin
          LerMem = 1'b1;
          IouD   = 1'b1;
        end
        S_MEM_WB: begin
          EscReg     = 1'b1;
          MemParaReg = 1'b1;
          instr_fim  = 1'b1;
        end
        S_MEM_WRITE: begin
          EscMem    = 1'b1;
          IouD      = 1'b1;
          instr_fim = mem_ready;
        end
        S_HALT:  parado = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: two instances (4-bit and 5-bit opcode),
// an instruction-level reference model checked every cycle, and directed
// literal checks at key points of each instruction.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [4:0] opc [2];
  logic [24:0] vec [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int OW = (k == 0) ? 4 : 5;
    logic       ecc, ecp, eir, ereg, lm, em, iod, rdst, mpr, ua, fim, err, par;
    logic [1:0] ub, fcp;
    logic [3:0] uop, est;
    controle_multiciclo #(.OPCODE_W(OW), .NUM_ALU_OPS(11)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opc[k][OW-1:0]), .mem_ready(mem_ready),
      .EscCondCP(ecc), .EscCP(ecp), .EscIR(eir), .EscReg(ereg), .LerMem(lm),
      .EscMem(em), .IouD(iod), .RegDst(rdst), .MemParaReg(mpr), .ULA_A(ua),
      .ULA_B(ub), .ULA_OP(uop), .FonteCP(fcp), .estado(est),
      .instr_fim(fim), .erro_op(err), .parado(par));
    assign vec[k] = {ecc, ecp, eir, ereg, lm, em, iod, rdst, mpr, ua,
                     ub, uop, fcp, est, fim, err, par};
  end

  // ---------------- reference model (instruction level) ----------------
  localparam logic [31:0] IMM = 32'h07C4;
  bit m_act [2];
  int m_ph  [2];
  int m_seq [2][3];
  int m_len [2];
  int m_idx [2];
  int m_opl [2];
  bit m_rd  [2];

  function automatic int cur_op(int k);
    return int'(opc[k]) & ((k == 0) ? 15 : 31);
  endfunction

  function automatic bit is_ill(int op);
    return !(op < 11) && !(op >= 11 && op <= 15);
  endfunction

  task automatic m_reset(input int k);
    m_act[k] = 0; m_ph[k] = 0; m_len[k] = 0; m_idx[k] = 0;
  endtask

  task automatic m_load(input int k, input int n, input int a, input int b, input int c);
    m_seq[k][0] = a; m_seq[k][1] = b; m_seq[k][2] = c;
    m_len[k] = n; m_idx[k] = 0;
  endtask

  task automatic m_adv(input int k);
    if (m_idx[k] < m_len[k]) begin
      m_ph[k] = m_seq[k][m_idx[k]];
      m_idx[k]++;
    end else begin
      m_ph[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) m_reset(k);
      else if (!m_act[k]) m_act[k] = 1;
      else begin
        case (m_ph[k])
          0: if (mem_ready) m_ph[k] = 1;
          1: begin
            int op;
            op = cur_op(k);
            m_opl[k] = op;
            if (op < 11) begin
              m_rd[k] = !IMM[op];
              m_load(k, 2, IMM[op] ? 3 : 2, 4, 0);
            end else if (op == 11) m_load(k, 1, 6, 0, 0);
            else if (op == 12) m_load(k, 1, 5, 0, 0);
            else if (op == 13) m_load(k, 3, 7, 8, 9);
            else if (op == 14) m_load(k, 2, 7, 10, 0);
            else if (op == 15) m_load(k, 1, 11, 0, 0);
            else m_load(k, 0, 0, 0, 0);
            m_adv(k);
          end
          8, 10: if (mem_ready) m_adv(k);
          11: ;
          default: m_adv(k);
        endcase
      end
    end
  end

  always @(negedge rst_n) for (int k = 0; k < 2; k++) m_reset(k);

  function automatic logic [24:0] exp_vec(bit act, int ph, bit rdy, bit rd, int opl, bit ill);
    logic ecc = 0, ecp = 0, eir = 0, ereg = 0, lm = 0, em = 0, iod = 0;
    logic rdst = 0, mpr = 0, ua = 0, fim = 0, err = 0, par = 0;
    logic [1:0] ub = 0, fcp = 0;
    logic [3:0] uop = 0;
    if (!act) return '0;
    case (ph)
      0:  begin lm = 1; ub = 1; eir = rdy; ecp = rdy; end
      1:  begin ub = 2; err = ill; fim = ill; end
      2:  begin ua = 1; uop = 4'(opl); end
      3:  begin ua = 1; ub = 2; uop = 4'(opl); end
      4:  begin ereg = 1; rdst = rd; fim = 1; end
      5:  begin ua = 1; uop = 1; ecc = 1; fcp = 1; fim = 1; end
      6:  begin ecp = 1; fcp = 2; fim = 1; end
      7:  begin ua = 1; ub = 2; end
      8:  begin lm = 1; iod = 1; end
      9:  begin ereg = 1; mpr = 1; fim = 1; end
      10: begin em = 1; iod = 1; fim = rdy; end
      11: par = 1;
      default: ;
    endcase
    return {ecc, ecp, eir, ereg, lm, em, iod, rdst, mpr, ua, ub, uop, fcp,
            4'(ph), fim, err, par};
  endfunction

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [24:0] e;
      e = exp_vec(m_act[k], m_ph[k], mem_ready, m_rd[k], m_opl[k], is_ill(cur_op(k)));
      n_chk++;
      if (vec[k] === e) n_pass++;
      else $display("FAIL cycle_vec dut%0d t=%0t got=%h exp=%h", k, $time, vec[k], e);
    end
  end

  // ---------------- directed stimulus with literal checks ----------------
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op);
    opc[0] = 5'(op);
    opc[1] = 5'(op);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; set_op(0);
    repeat (3) cyc();
    chk("rst_estado", int'(g_dut[0].est), 0);
    chk("rst_lermem", int'(g_dut[0].lm), 0);
    rst_n = 1'b1;
    // ALU R-class, opcode 0
    cyc(); chk("r_fetch_est", int'(g_dut[0].est), 0); chk("r_fetch_escir", int'(g_dut[0].eir), 1);
           chk("r_fetch_esccp", int'(g_dut[0].ecp), 1);
    cyc(); chk("r_dec_est", int'(g_dut[0].est), 1);
    cyc(); chk("r_exec_est", int'(g_dut[0].est), 2); chk("r_exec_ulaop", int'(g_dut[0].uop), 0);
    cyc(); chk("r_wb_est", int'(g_dut[0].est), 4); chk("r_wb_escreg", int'(g_dut[0].ereg), 1);
           chk("r_wb_regdst", int'(g_dut[0].rdst), 1);
    cyc(); chk("r_end_est", int'(g_dut[0].est), 0);
    // ALU I-class, opcode 2, fetch stalled
    set_op(2); mem_ready = 1'b0; #1;
    chk("i_stall_escir", int'(g_dut[0].eir), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("i_stall_est", int'(g_dut[0].est), 0); chk("i_stall_lermem", int'(g_dut[0].lm), 1);
    end
    mem_ready = 1'b1; #1; chk("i_ready_escir", int'(g_dut[0].eir), 1);
    cyc(); chk("i_dec_est", int'(g_dut[0].est), 1);
    cyc(); chk("i_exec_est", int'(g_dut[0].est), 3); chk("i_exec_ulab", int'(g_dut[0].ub), 2);
    cyc(); chk("i_wb_regdst", int'(g_dut[0].rdst), 0); chk("i_wb_escreg", int'(g_dut[0].ereg), 1);
    cyc(); chk("i_end_est", int'(g_dut[0].est), 0);
    // LW with two wait cycles
    set_op(13);
    cyc(); chk("lw_dec", int'(g_dut[0].est), 1);
    cyc(); chk("lw_addr", int'(g_dut[0].est), 7); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("lw_read", int'(g_dut[0].est), 8); chk("lw_iou", int'(g_dut[0].iod), 1);
    end
    mem_ready = 1'b1;
    cyc(); chk("lw_wb", int'(g_dut[0].est), 9); chk("lw_memparareg", int'(g_dut[0].mpr), 1);
           chk("lw_fim", int'(g_dut[0].fim), 1);
    cyc(); chk("lw_end", int'(g_dut[0].est), 0);
    // SW then BEQ
    set_op(14);
    cyc(); cyc(); chk("sw_addr", int'(g_dut[0].est), 7);
    cyc(); chk("sw_write", int'(g_dut[0].est), 10); chk("sw_escmem", int'(g_dut[0].em), 1);
           chk("sw_fim", int'(g_dut[0].fim), 1);
    cyc(); chk("sw_end", int'(g_dut[0].est), 0);
    set_op(12);
    cyc(); cyc(); chk("beq_est", int'(g_dut[0].est), 5); chk("beq_cond", int'(g_dut[0].ecc), 1);
           chk("beq_fontecp", int'(g_dut[0].fcp), 1); chk("beq_ulaop", int'(g_dut[0].uop), 1);
    cyc(); chk("beq_end", int'(g_dut[0].est), 0);
    // Jump on 4-bit instance, illegal opcode 20 on 5-bit instance
    opc[0] = 5'd11; opc[1] = 5'd20;
    cyc(); chk("ill_err", int'(g_dut[1].err), 1); chk("ill_fim", int'(g_dut[1].fim), 1);
           chk("ill_escreg", int'(g_dut[1].ereg), 0); chk("ill_escmem", int'(g_dut[1].em), 0);
    cyc(); chk("ill_back", int'(g_dut[1].est), 0); chk("ill_err_off", int'(g_dut[1].err), 0);
           chk("jmp_est", int'(g_dut[0].est), 6); chk("jmp_fontecp", int'(g_dut[0].fcp), 2);
    // HALT, then reset out of it
    set_op(15);
    repeat (22) cyc();
    chk("halt_parado0", int'(g_dut[0].par), 1); chk("halt_est0", int'(g_dut[0].est), 11);
    chk("halt_parado1", int'(g_dut[1].par), 1);
    #2 rst_n = 1'b0; #1;
    chk("hrst_est", int'(g_dut[0].est), 0); chk("hrst_parado", int'(g_dut[0].par), 0);
    chk("hrst_lermem", int'(g_dut[1].lm), 0);
    cyc(); cyc(); chk("hrst_hold", int'(g_dut[0].lm), 0);
    rst_n = 1'b1; set_op(14); mem_ready = 1'b1;
    cyc(); chk("sw2_fetch", int'(g_dut[0].lm), 1);
    cyc(); cyc(); chk("sw2_addr", int'(g_dut[0].est), 7); mem_ready = 1'b0;
    cyc(); chk("sw2_write", int'(g_dut[0].em), 1); chk("sw2_nofim", int'(g_dut[0].fim), 0);
    cyc(); chk("sw2_hold", int'(g_dut[0].em), 1);
    #2 rst_n = 1'b0; #1;
    chk("sw2_abort_escmem", int'(g_dut[0].em), 0); chk("sw2_abort_est", int'(g_dut[0].est), 0);
    cyc(); rst_n = 1'b1;
    // Directed program with a fixed memory-ready pattern; model checks each cycle
    begin
      int ops [9] = '{0, 5, 11, 12, 13, 14, 3, 10, 7};
      for (int i = 0; i < 9; i++) begin
        set_op(ops[i]);
        for (int j = 0; j < 8; j++) begin
          mem_ready = ((i + j) % 3) != 0;
          cyc();
        end
      end
    end
    #6;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Parametrised multicycle control unit for the datapath (PC, IR, register bank, ULA, unified memory).
- Explicit FSM with per-class instruction sequences: ALU reg/imm, jump, branch-if-equal, load, store, halt.
- Memory accesses use a ready handshake; the FSM always restarts at FETCH after each instruction.
- Outputs decode the current state (plus mem_ready during memory waits) into the datapath control lines.

Parameters:
- OPCODE_W, 4, opcode width.
- ULA_OP_W, 4, width of ULA_OP.
- NUM_ALU_OPS, 11, opcodes 0..NUM_ALU_OPS-1 are ALU instructions.
- IMM_MASK, 16'h07C4, bit i set means ALU opcode i uses the immediate operand. Width is 2**OPCODE_W.
- OP_JUMP, 11; OP_BEQ, 12; OP_LW, 13; OP_SW, 14; OP_HALT, 15. Special opcodes.
- ULA_ADD, 0; ULA_SUB, 1. ULA_OP codes used for PC/address arithmetic and compare.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  from IR; stable from DECODE until the instruction ends.
- mem_ready  in  1  memory completed the current access this cycle.
- EscCondCP  out  1  conditional PC write (qualified by ULA zero in the datapath).
- EscCP  out  1  unconditional PC write.
- EscIR  out  1  IR load.
- EscReg  out  1  register bank write.
- LerMem  out  1  memory read request.
- EscMem  out  1  memory write request.
- IouD  out  1  memory address select: 0=PC, 1=ULAOut.
- RegDst  out  1  destination register select: 1=rd, 0=rt.
- MemParaReg  out  1  write-back data select: 1=MDR, 0=ULAOut.
- ULA_A  out  1  ULA A source: 0=PC, 1=reg A.
- ULA_B  out  2  ULA B source: 00=reg B, 01=const 1, 10=imm.
- ULA_OP  out  ULA_OP_W  ULA operation.
- FonteCP  out  2  PC source: 00=ULA, 01=ULAOut, 10=jump target.
- estado  out  4  current state, for debug.
- instr_fim  out  1  one-cycle pulse on the last cycle of each instruction.
- erro_op  out  1  one-cycle pulse in DECODE on an illegal opcode.
- parado  out  1  high while in HALT.

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all outputs forced 0, including estado.
- After reset release, outputs follow state decode from the next edge.
- Every control line not listed for a state below is 0.
- FETCH:
  - LerMem=1, IouD=0, ULA_A=0, ULA_B=01, ULA_OP=ULA_ADD, FonteCP=00.
  - EscIR=EscCP=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ULA_A=0, ULA_B=10, ULA_OP=ULA_ADD (branch target into ULAOut).
  - Latches the instruction class.
  - ALU opcode: IMM_MASK bit set goes to EXEC_I, otherwise EXEC_R.
  - OP_JUMP goes to JUMP; OP_BEQ to BRANCH; OP_LW/OP_SW to MEM_ADDR; OP_HALT to HALT.
  - Any other opcode: erro_op=1, instr_fim=1, go to FETCH.
- EXEC_R: ULA_A=1, ULA_B=00, ULA_OP=opcode (zero-extended or truncated to ULA_OP_W); go to WB_ALU.
- EXEC_I: same as EXEC_R but ULA_B=10; go to WB_ALU.
- WB_ALU: EscReg=1, MemParaReg=0, RegDst=1 for R-class and 0 for I-class; instr_fim=1; go to FETCH.
- JUMP: EscCP=1, FonteCP=10, instr_fim=1; go to FETCH.
- BRANCH: ULA_A=1, ULA_B=00, ULA_OP=ULA_SUB, EscCondCP=1, FonteCP=01, instr_fim=1; go to FETCH.
- MEM_ADDR: ULA_A=1, ULA_B=10, ULA_OP=ULA_ADD; OP_LW goes to MEM_READ, OP_SW to MEM_WRITE.
- MEM_READ: LerMem=1, IouD=1; wait for mem_ready=1, then go to MEM_WB.
- MEM_WB: EscReg=1, MemParaReg=1, RegDst=0, instr_fim=1; go to FETCH.
- MEM_WRITE: EscMem=1, IouD=1; wait for mem_ready=1; on that cycle instr_fim=1; go to FETCH.
- HALT: parado=1, no writes; stays in HALT until rst_n=0.
- LerMem/EscMem are held steady throughout a wait. A mem_ready pulse in a non-memory state is ignored.
- Latency with zero-wait memory (cycles from FETCH entry): ALU=4, JUMP=3, BEQ=3, LW=5, SW=4. Each memory wait cycle adds 1.
- A change of opcode mid-instruction does not alter the sequence; the class is latched in DECODE.
- Reset asserted mid-instruction aborts immediately: no further writes, and the FSM restarts at FETCH.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, BRANCH=5, JUMP=6, MEM_ADDR=7, MEM_READ=8, MEM_WB=9, MEM_WRITE=10, HALT=11.

Test Plan:
- Reset with mem_ready=1, then opcode=0: estado 0,1,2,4,0; EscIR/EscCP high in cycle 1; EscReg=1, RegDst=1 in cycle 4; ULA_OP=0 in EXEC_R.
- opcode=2, mem_ready stuck 0 for 3 cycles in FETCH: LerMem held 3 extra cycles, EscIR=0 until ready; then EXEC_I with ULA_B=10; WB with RegDst=0.
- opcode=13, memory ready after 2 wait cycles in MEM_READ: states 0,1,7,8,8,8,9; MEM_WB has EscReg=1, MemParaReg=1; instr_fim once.
- opcode=14 then opcode=12: EscMem=1, IouD=1 in MEM_WRITE. Branch state has EscCondCP=1, FonteCP=01, ULA_OP=1. Instruction lengths 4 and 3 cycles.
- opcode=15: reaches HALT with parado=1 and stays there for 20 cycles. rst_n pulse returns to FETCH with all outputs 0 during reset.
- With OPCODE_W=5 and NUM_ALU_OPS=11, opcode=20: erro_op pulses in DECODE, back to FETCH, no write strobes. Separately, rst_n low during MEM_WRITE clears EscMem asynchronously.
